// File: rtl/datapath_accumulator.sv
// ============================================================================
// Module   : datapath_accumulator
// Purpose  : Source-selected accumulator with load/add/sub/clear and a
//            bit-serial shifter, plus completion and status flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module datapath_accumulator #(
  parameter  int WIDTH   = 16,
  parameter  int NUM_SRC = 4,
  localparam int SEL_W   = $clog2(NUM_SRC),
  localparam int SHW     = $clog2(WIDTH) + 1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         src_sel,
  input  logic [2:0]               op,
  input  logic                     op_valid,
  output logic                     op_ready,
  output logic [WIDTH-1:0]         operand,
  output logic [WIDTH-1:0]         acc_out,
  output logic                     done,
  output logic                     flag_zero,
  output logic                     flag_carry
);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_SHL   = 3'b100;
  localparam logic [2:0] OP_SHR   = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             dir_q, dir_d;      // 1 = shift right
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SHW-1:0]   w_n_raw;
  logic [SHW-1:0]   w_n;
  logic [WIDTH-1:0] w_step_acc;
  logic             w_step_out;

  // Out-of-range selects fall through to source 0.
  always_comb begin
    operand = src_data[WIDTH-1:0];
    for (int i = 1; i < NUM_SRC; i++) begin
      if (src_sel == SEL_W'(i)) operand = src_data[i*WIDTH +: WIDTH];
    end
  end

  assign w_sum      = {1'b0, acc_q} + {1'b0, operand};
  assign w_diff     = {1'b0, acc_q} - {1'b0, operand};
  assign w_n_raw    = operand[SHW-1:0];
  assign w_n        = (w_n_raw > SHW'(WIDTH)) ? SHW'(WIDTH) : w_n_raw;
  assign w_step_acc = dir_q ? (acc_q >> 1) : (acc_q << 1);
  assign w_step_out = dir_q ? acc_q[0] : acc_q[WIDTH-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          done_d = 1'b1;
          case (op)
            OP_LOAD: begin
              acc_d   = operand;
              carry_d = 1'b0;
              zero_d  = (operand == '0);
            end
            OP_ADD: begin
              acc_d   = w_sum[WIDTH-1:0];
              carry_d = w_sum[WIDTH];
              zero_d  = (w_sum[WIDTH-1:0] == '0);
            end
            OP_SUB: begin
              acc_d   = w_diff[WIDTH-1:0];
              carry_d = w_diff[WIDTH];
              zero_d  = (w_diff[WIDTH-1:0] == '0);
            end
            OP_SHL, OP_SHR: begin
              if (w_n == '0) begin
                zero_d = (acc_q == '0);
              end else begin
                done_d  = 1'b0;
                state_d = S_SHIFT;
                cnt_d   = w_n;
                dir_d   = (op == OP_SHR);
              end
            end
            OP_CLEAR: begin
              acc_d   = '0;
              carry_d = 1'b0;
              zero_d  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_SHIFT: begin
        acc_d   = w_step_acc;
        carry_d = w_step_out;
        cnt_d   = cnt_q - 1'b1;
        // Zero flag only reflects completed operations, not shift steps.
        if (cnt_q == SHW'(1)) begin
          done_d  = 1'b1;
          zero_d  = (w_step_acc == '0);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign op_ready   = (state_q == S_IDLE);
  assign acc_out    = acc_q;
  assign done       = done_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_datapath_accumulator.sv
// ============================================================================
// Module   : tb_datapath_accumulator
// Purpose  : Directed self-checking bench for datapath_accumulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_datapath_accumulator;

  logic        CLK;
  logic        RST_N;
  logic [63:0] src_data;
  logic [1:0]  src_sel;
  logic [2:0]  op;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] operand;
  logic [15:0] acc_out;
  logic        done;
  logic        flag_zero;
  logic        flag_carry;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] NOP = 3'b000, LOAD = 3'b001, ADD = 3'b010, SUB = 3'b011;
  localparam logic [2:0] SHL = 3'b100, SHR = 3'b101, CLR = 3'b110;

  datapath_accumulator #(.WIDTH(16), .NUM_SRC(4)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .src_data   (src_data),
    .src_sel    (src_sel),
    .op         (op),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .operand    (operand),
    .acc_out    (acc_out),
    .done       (done),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [15:0] v);
    src_sel        = 2'd0;
    src_data[15:0] = v;
    op             = o;
    op_valid       = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    RST_N = 1'b0; op_valid = 1'b0; op = NOP; src_sel = 2'd0; src_data = '0;
    #3;
    checks++; if (acc_out !== 16'h0) begin errors++; $display("FAIL reset_acc: got %h expected 0000", acc_out); end
    checks++; if ({done, flag_zero, flag_carry} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {done, flag_zero, flag_carry}); end
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", op_ready); end
    tick(); tick();
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_src_select();
    src_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    src_sel = 2'd2; op = LOAD; op_valid = 1'b1;
    #1;
    checks++; if (operand !== 16'h3333) begin errors++; $display("FAIL sel_operand: got %h expected 3333", operand); end
    tick();
    checks++; if (acc_out !== 16'h3333 || done !== 1'b1) begin errors++; $display("FAIL sel_load: got acc %h done %b expected 3333 1", acc_out, done); end
    src_sel = 2'd3; op = ADD;
    tick();
    checks++; if (acc_out !== 16'h7777 || flag_carry !== 1'b0 || flag_zero !== 1'b0) begin errors++; $display("FAIL sel_add: got acc %h c %b z %b expected 7777 0 0", acc_out, flag_carry, flag_zero); end
    op_valid = 1'b0;
    tick();
    checks++; if (done !== 1'b0 || acc_out !== 16'h7777) begin errors++; $display("FAIL idle_hold: got done %b acc %h expected 0 7777", done, acc_out); end
  endtask

  task automatic test_wrap();
    issue(LOAD, 16'hFFFF);
    issue(ADD, 16'h0001);
    checks++; if ({acc_out, flag_carry, flag_zero} !== {16'h0000, 2'b11}) begin errors++; $display("FAIL add_wrap: got acc %h c %b z %b expected 0000 1 1", acc_out, flag_carry, flag_zero); end
    issue(SUB, 16'h0001);
    checks++; if ({acc_out, flag_carry, flag_zero} !== {16'hFFFF, 2'b10}) begin errors++; $display("FAIL sub_borrow: got acc %h c %b z %b expected ffff 1 0", acc_out, flag_carry, flag_zero); end
    op_valid = 1'b0;
    tick();
  endtask

  task automatic test_shift();
    issue(LOAD, 16'h8421);
    issue(SHR, 16'h0004);
    // Held valid with a different op must be ignored until the shift ends.
    op = LOAD;
    checks++; if (op_ready !== 1'b0 || done !== 1'b0 || acc_out !== 16'h8421) begin errors++; $display("FAIL shr_accept: got rdy %b done %b acc %h expected 0 0 8421", op_ready, done, acc_out); end
    tick();
    checks++; if (acc_out !== 16'h4210 || flag_carry !== 1'b1 || op_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL shr_step1: got acc %h c %b rdy %b done %b expected 4210 1 0 0", acc_out, flag_carry, op_ready, done); end
    tick(); tick();
    checks++; if (op_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL shr_step3: got rdy %b done %b expected 0 0", op_ready, done); end
    tick();
    checks++; if ({acc_out, flag_carry, flag_zero, done, op_ready} !== {16'h0842, 4'b0011}) begin errors++; $display("FAIL shr_done: got acc %h c %b z %b done %b rdy %b expected 0842 0 0 1 1", acc_out, flag_carry, flag_zero, done, op_ready); end
    tick();
    checks++; if (acc_out !== 16'h0004 || done !== 1'b1) begin errors++; $display("FAIL post_shift_accept: got acc %h done %b expected 0004 1", acc_out, done); end
    op_valid = 1'b0;
    tick();
  endtask

  task automatic test_shift_bounds();
    int cycles;
    issue(LOAD, 16'h1235);
    issue(SHL, 16'h0020);
    checks++; if (acc_out !== 16'h1235 || done !== 1'b1 || op_ready !== 1'b1 || flag_carry !== 1'b0) begin errors++; $display("FAIL shift_n0: got acc %h done %b rdy %b c %b expected 1235 1 1 0", acc_out, done, op_ready, flag_carry); end
    issue(SHL, 16'h001F);
    op_valid = 1'b0;
    src_data[15:0] = 16'h0003;
    cycles = 0;
    while (done !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
    checks++; if (cycles !== 16) begin errors++; $display("FAIL shift_clamp_cycles: got %0d expected 16", cycles); end
    checks++; if ({acc_out, flag_carry, flag_zero} !== {16'h0000, 2'b11}) begin errors++; $display("FAIL shift_clamp_result: got acc %h c %b z %b expected 0000 1 1", acc_out, flag_carry, flag_zero); end
    issue(LOAD, 16'h8000);
    issue(SHL, 16'h0001);
    op_valid = 1'b0;
    tick();
    checks++; if ({acc_out, flag_carry, flag_zero, done} !== {16'h0000, 3'b111}) begin errors++; $display("FAIL shl_msb: got acc %h c %b z %b done %b expected 0000 1 1 1", acc_out, flag_carry, flag_zero, done); end
    tick();
  endtask

  task automatic test_back_to_back();
    issue(LOAD, 16'd5);
    checks++; if (acc_out !== 16'd5 || done !== 1'b1) begin errors++; $display("FAIL b2b_load: got acc %0d done %b expected 5 1", acc_out, done); end
    issue(ADD, 16'd3);
    checks++; if (acc_out !== 16'd8 || done !== 1'b1) begin errors++; $display("FAIL b2b_add: got acc %0d done %b expected 8 1", acc_out, done); end
    issue(SUB, 16'd8);
    checks++; if (acc_out !== 16'd0 || done !== 1'b1 || flag_zero !== 1'b1 || flag_carry !== 1'b0) begin errors++; $display("FAIL b2b_sub: got acc %0d done %b z %b c %b expected 0 1 1 0", acc_out, done, flag_zero, flag_carry); end
    issue(NOP, 16'd7);
    checks++; if (acc_out !== 16'd0 || done !== 1'b1 || flag_zero !== 1'b1) begin errors++; $display("FAIL b2b_nop: got acc %0d done %b z %b expected 0 1 1", acc_out, done, flag_zero); end
    issue(CLR, 16'd9);
    checks++; if (acc_out !== 16'd0 || done !== 1'b1 || flag_zero !== 1'b1) begin errors++; $display("FAIL b2b_clear: got acc %0d done %b z %b expected 0 1 1", acc_out, done, flag_zero); end
    op_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_shift();
    issue(LOAD, 16'h8001);
    issue(SHL, 16'h0005);
    op_valid = 1'b0;
    tick(); tick();
    RST_N = 1'b0;
    #1;
    checks++; if (acc_out !== 16'h0000 || {done, flag_zero, flag_carry} !== 3'b000 || op_ready !== 1'b1) begin errors++; $display("FAIL mid_shift_reset: got acc %h flags %b rdy %b expected 0000 000 1", acc_out, {done, flag_zero, flag_carry}, op_ready); end
    #2;
    RST_N = 1'b1;
    issue(LOAD, 16'h0003);
    checks++; if (acc_out !== 16'h0003 || done !== 1'b1) begin errors++; $display("FAIL post_reset_load: got acc %h done %b expected 0003 1", acc_out, done); end
    op_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_src_select();
    test_wrap();
    test_shift();
    test_shift_bounds();
    test_back_to_back();
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/datapath_accumulator.md
# datapath_accumulator

Parametrised accumulator section for the datapath: selects one of `NUM_SRC` operand sources, applies a load/add/sub/clear or a multi-cycle bit-serial shift to a `WIDTH`-bit accumulator register, and reports completion and status flags. It is the next generation of the existing two-mux-plus-register datapath section. It sits between the operand/register-value buses and the `a0` consumers. The accepting handshake lets the controller issue operations without tracking shift latency.

## Interface
Parameters:
- `WIDTH`, 16, accumulator and operand width (≥ 2)
- `NUM_SRC`, 4, number of operand sources (≥ 2)
- `SEL_W`, `$clog2(NUM_SRC)`, source-select width (derived, not overridden)
- `SHW`, `$clog2(WIDTH)+1`, shift-amount field width (derived)

Ports:
- `CLK` in 1: single clock, rising edge
- `RST_N` in 1: asynchronous, active-low reset
- `src_data` in `NUM_SRC*WIDTH`: packed operands; source i = `src_data[i*WIDTH +: WIDTH]`
- `src_sel` in `SEL_W`: operand select; values ≥ `NUM_SRC` select source 0
- `op` in 3: operation code (see Operation)
- `op_valid` in 1: operation request
- `op_ready` out 1: block can accept an op (combinational from state)
- `operand` out `WIDTH`: combinational selected source (tap equivalent to old `a0`)
- `acc_out` out `WIDTH`: accumulator register
- `done` out 1: registered one-cycle pulse, final result present on `acc_out`
- `flag_zero` out 1: `acc_out == 0` after last completed op
- `flag_carry` out 1: carry/borrow/shifted-out bit of last completed op

## Operation
- Accept on a rising edge with `op_valid && op_ready`. Without acceptance, `acc_out` and the flags hold and `done` = 0.
- Op codes:
  - 000 NOP: `done` pulses; acc and flags unchanged.
  - 001 LOAD: acc = operand; carry = 0.
  - 010 ADD: {carry, acc} = acc + operand, computed WIDTH+1 bits wide, so it wraps mod 2^WIDTH.
  - 011 SUB: acc = acc − operand mod 2^WIDTH; carry = borrow (operand > acc, unsigned).
  - 100 SHL: logical left shift by n, one bit per cycle.
  - 101 SHR: logical right shift by n, one bit per cycle.
  - 110 CLEAR: acc = 0; carry = 0.
  - 111: treated as NOP.
- Shift amount: n = `operand[SHW-1:0]`, clamped to `WIDTH`. It is latched at acceptance; later changes to the operand are ignored.
- Each shift step: carry = the bit shifted out; a 0 is shifted in.
- With n = `WIDTH`, the result is 0 and carry is the last original bit shifted out.
- State machine:
  - IDLE: `op_ready` = 1.
    - Single-cycle op or shift with n = 0: complete at the accept edge, stay IDLE. An n = 0 shift leaves acc and carry unchanged.
    - Shift with n ≥ 1: latch direction and n into the counter, go to SHIFT. acc is not modified at the accept edge.
  - SHIFT: `op_ready` = 0. Each edge shifts 1 bit and decrements the counter. The edge where the counter goes 1→0 sets `done` and returns to IDLE.
- `flag_zero` updates on the completing edge only, from the new acc value. It does not update at intermediate shift steps. `flag_carry` updates at every shift step.
- `op_valid` or `op` changes while in SHIFT are ignored.

## Timing
- Reset (`RST_N` low, asynchronous, at any time including mid-shift):
  - acc_out = 0, done = 0, flag_zero = 0, flag_carry = 0.
  - state = IDLE, counter = 0, so `op_ready` = 1 immediately.
- Single-cycle op accepted at edge k: new `acc_out` and flags are visible after edge k, and `done` = 1 for exactly cycle k→k+1.
- Shift of n ≥ 1 accepted at edge k:
  - `op_ready` = 0 from k to k+n.
  - Final result and `done` appear after edge k+n.
  - `op_ready` = 1 again after edge k+n.
  - Total latency is n cycles.
- Back-to-back single-cycle ops: one per cycle, with `done` high continuously.
- A new op may be accepted on the edge right after a shift completes (k+n+1).
- `operand` and `op_ready` are combinational; all other outputs are registered.

## Test plan
- Reset mid-shift: LOAD 0x8001, SHL n=5, assert `RST_N`=0 two cycles after acceptance → immediately acc_out=0, all flags 0, op_ready=1; after release, LOAD 0x0003 accepted next edge.
- Source select (NUM_SRC=4): sources 0x1111, 0x2222, 0x3333, 0x4444 →
  - sel=2, LOAD → acc_out=0x3333, done one cycle.
  - sel=3, ADD → acc_out=0x7777, carry=0.
- Wrap/borrow:
  - LOAD 0xFFFF, ADD 0x0001 → acc_out=0x0000, carry=1, zero=1.
  - Then SUB 0x0001 → 0xFFFF, carry=1, zero=0.
- Multi-cycle shift: LOAD 0x8421, SHR n=4 → op_ready low 4 cycles, op_valid held high during SHIFT is ignored, done after 4th edge, acc_out=0x0842, carry=0.
- Shift boundaries:
  - n=0 → single-cycle done, acc unchanged.
  - n=31 clamps to 16 → 16 cycles, acc_out=0.
  - SHL of 0x8000 by n=1 → acc_out=0x0000, carry=1, zero=1.
- Throughput: stream LOAD 5, ADD 3, SUB 8, NOP, CLEAR on consecutive cycles →
  - acc_out sequence 5, 8, 0, 0, 0.
  - done continuously high.
  - zero=1 after the SUB.
